// File: rtl/run_det_pkg.sv
// run_det_pkg: shared run-state and mode encodings for the run detector.
package run_det_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN0 = 2'd1, RUN1 = 2'd2} st_t;
  localparam logic [1:0] MODE_BOTH = 2'd0;
  localparam logic [1:0] MODE_ZERO = 2'd1;
  localparam logic [1:0] MODE_ONE  = 2'd2;
  localparam logic [1:0] MODE_OFF  = 2'd3;
endpackage

// File: rtl/run_detector_ch.sv
// run_detector_ch: single-channel run FSM, saturating run counter, z/z_rise and event counter.
// Event counter is built only when RUN_DET_EVT_CNT_EN is defined.
module run_detector_ch
  import run_det_pkg::*;
#(
  parameter int MAX_RUN = 8,
  parameter int CNT_W   = 4,
  parameter int EVT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic [CNT_W-1:0] teff,
  input  logic [1:0]       mode,
  output logic             z,
  output logic             z_rise,
  output logic [CNT_W-1:0] run_len,
  output logic [EVT_W-1:0] evt_cnt
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_RUN);
  st_t st, st_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic z_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      st  <= IDLE;
      cnt <= '0;
      z_q <= 1'b0;
    end else begin
      st  <= st_nx;
      cnt <= cnt_nx;
      z_q <= z;
    end
  end
  always_comb begin
    st_nx  = st;
    cnt_nx = cnt;
    if (in_valid) begin
      st_nx  = in_bit ? RUN1 : RUN0;
      cnt_nx = (st == st_nx) ? ((cnt == MAX_C) ? cnt : cnt + 1'b1) : CNT_W'(1);
    end
  end
  assign z = ((st == RUN0 && (mode == MODE_BOTH || mode == MODE_ZERO)) ||
              (st == RUN1 && (mode == MODE_BOTH || mode == MODE_ONE))) && (cnt >= teff);
  assign z_rise  = z & ~z_q;
  assign run_len = cnt;
`ifdef RUN_DET_EVT_CNT_EN
  logic [EVT_W-1:0] evt;
  always_ff @(posedge clk) begin
    if (reset) evt <= '0;
    else if (z_rise && evt != '1) evt <= evt + 1'b1;
  end
  assign evt_cnt = evt;
`else
  assign evt_cnt = '0;
`endif
endmodule

// File: rtl/run_detector.sv
// run_detector: CH independent run-length detectors sharing one clamped threshold and mode.
// Optional per-channel event counters enabled by RUN_DET_EVT_CNT_EN.
module run_detector
  import run_det_pkg::*;
#(
  parameter int CH      = 1,
  parameter int MAX_RUN = 8,
  parameter int CNT_W   = $clog2(MAX_RUN + 1),
  parameter int EVT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [CH-1:0]       in_bit,
  input  logic [CNT_W-1:0]    thresh,
  input  logic [1:0]          mode,
  output logic [CH-1:0]       z,
  output logic [CH-1:0]       z_rise,
  output logic [CH*CNT_W-1:0] run_len,
  output logic [CH*EVT_W-1:0] evt_cnt
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_RUN);
  logic [CNT_W-1:0] teff;
  assign teff = (thresh == '0) ? CNT_W'(1) : (thresh > MAX_C) ? MAX_C : thresh;
  genvar i;
  for (i = 0; i < CH; i++) begin : g_ch
    run_detector_ch #(.MAX_RUN(MAX_RUN), .CNT_W(CNT_W), .EVT_W(EVT_W)) u_ch (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_bit(in_bit[i]),
      .teff(teff),
      .mode(mode),
      .z(z[i]),
      .z_rise(z_rise[i]),
      .run_len(run_len[i*CNT_W +: CNT_W]),
      .evt_cnt(evt_cnt[i*EVT_W +: EVT_W])
    );
  end
endmodule

// File: doc/run_detector.md
Name: run_detector

Overview:
- Multi-channel, parametrised run-length detector for serial bit streams.
- Flags when a stream has carried N consecutive identical bits (zeros, ones, or either).
- N and polarity are selected at runtime.
- Used on keyboard/serial front ends to detect stuck lines, idle conditions and framing runs. Replaces fixed-length, hard-coded-state detectors with a counter-based Moore machine per channel.

Parameters:
- CH, 1, number of independent channels.
- MAX_RUN, 8, saturation limit of the run counter; largest usable threshold.
- CNT_W, $clog2(MAX_RUN+1), run counter width (derived; do not override).
- EVT_W, 8, event counter width (optional feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  sample strobe, shared by all channels.
- in_bit  in  CH  serial bit per channel, sampled when in_valid=1.
- thresh  in  CNT_W  required run length N, shared by all channels.
- mode  in  2  00 = either polarity, 01 = zeros only, 10 = ones only, 11 = detection disabled.
- z  out  CH  level: run condition currently met.
- z_rise  out  CH  one-cycle pulse on each 0->1 transition of z.
- run_len  out  CH*CNT_W  current run length per channel; channel i at [i*CNT_W +: CNT_W].
- evt_cnt  out  CH*EVT_W  detection event count per channel (optional feature).

Behaviour:
- Per-channel state is {st, cnt}. st is IDLE, RUN0 or RUN1; cnt is a CNT_W saturating counter.
- Reset: st=IDLE, cnt=0, z=0, z_rise=0, run_len=0, evt_cnt=0.
- A reset asserted mid-run takes effect at the next edge and has priority over in_valid.
- in_valid=0: st and cnt hold. No channel advances.
- in_valid=1, sample b:
  - st=IDLE -> st=RUNb, cnt=1.
  - st=RUNb (same polarity) -> cnt=min(cnt+1, MAX_RUN).
  - Opposite polarity -> st=RUNb, cnt=1.
- Effective threshold: teff = 1 if thresh=0; MAX_RUN if thresh>MAX_RUN; otherwise thresh.
- z (Moore): z = (st!=IDLE) && (cnt>=teff) && polarity enabled by mode.
  - RUN0 is enabled by mode 00 or 01; RUN1 by mode 00 or 10; mode 11 forces z=0.
  - z is combinational from registered state plus the live thresh and mode.
  - z rises in the cycle after the edge that captures the N-th consecutive equal sample (1-cycle latency).
  - A change to thresh or mode affects z in the same cycle.
- Saturation: cnt stops at MAX_RUN. z stays high for as long as the run continues. No wrap-around.
- z_rise: z & ~z_q, where z_q is z registered (z_q=0 in reset). z_rise therefore fires once per assertion, including assertions caused by a thresh/mode change.
- run_len = cnt, reported regardless of mode.
- Channels are fully independent; identical simultaneous events on several channels are handled in parallel.

Optional Feature:
- Macro RUN_DET_EVT_CNT_EN.
- Defined: each channel has an EVT_W-bit counter that increments on every z_rise and saturates at all-ones. It is cleared only by reset. evt_cnt reports it.
- Undefined: no counter is implemented and evt_cnt is tied to 0. The port list is identical in both builds.

Decomposition:
- Package run_det_pkg holds:
  - st encodings: IDLE=2'd0, RUN0=2'd1, RUN1=2'd2.
  - mode encodings: MODE_BOTH, MODE_ZERO, MODE_ONE, MODE_OFF.
- Sub-module run_detector_ch is the single-channel FSM, counter, z/z_rise logic and optional event counter.
- The top instantiates CH copies in a generate loop and handles the teff clamp once, shared by all channels.

Test Plan:
All scenarios use CH=2, MAX_RUN=8, thresh=4, mode=00 unless stated.
1. ch0 samples 0,0,0,0 with in_valid=1 every cycle -> z[0]=0 through the 4th sample edge, z[0]=1 the following cycle; z_rise[0] high exactly 1 cycle; run_len[0]=4; ch1 unaffected.
2. ch0 samples 1,1,1,0,1,1,1,1 -> run_len[0] goes 1,2,3,1,1,2,3,4; z[0] asserts only after the 8th sample.
3. mode=01, ch0 samples five 1s -> z[0]=0, run_len[0]=5. Then switch mode to 00 -> z[0]=1 and z_rise[0]=1 in the same cycle as the switch.
4. ch0 samples 0,0,0,0 with in_valid low between every valid sample -> cnt holds during the gaps; z[0] asserts after the 4th valid sample. thresh=0 with a single sample -> z=1. thresh=15 with 9 ones -> z asserts once cnt saturates at 8.
5. Twelve consecutive 1s on ch1 -> run_len[1] saturates at 8, z[1] stays high, one z_rise[1]. Assert reset mid-run -> z[1]=0 and run_len[1]=0 the next cycle.
6. Three separated 4-zero runs on ch0 -> evt_cnt[0]=3 with RUN_DET_EVT_CNT_EN defined; evt_cnt=0 without it.
